// File: rtl/div_unit_seq.sv
// Sequential signed divider for the HI/LO path: restoring shift-subtract, one
// quotient bit per clock, sign fix-up in a final cycle. lo=quotient, hi=remainder.
module div_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] babs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic             start;
  logic             zero_div;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             fits;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign start     = ((state == IDLE) || (state == DONE)) && div_control;
  assign zero_div  = (b == '0);
  assign rem_shift = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, babs};
  assign fits      = (rem_shift >= {1'b0, babs});

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = (start && !zero_div) ? RUN : IDLE;
      RUN:        state_nxt = (cnt == '0) ? FIX : RUN;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      babs     <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_zero <= start && zero_div;
      case (state)
        IDLE, DONE: begin
          if (start && !zero_div) begin
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            q      <= abs_val(a);
            babs   <= abs_val(b);
            rem    <= '0;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        // One quotient bit per cycle; the compare is WIDTH+1 bits wide so
        // a divisor of 0x80000000 still compares correctly.
        RUN: begin
          if (fits) begin
            rem <= rem_diff;
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo <= cond_neg(q, sign_q);
          hi <= cond_neg(rem[WIDTH-1:0], sign_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_seq.sv
// Bench for div_unit_seq: vector table, corner sequences (zero divisor,
// ignored start, reset mid-run) and random operands against a reference model.
module tb_div_unit_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_control;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  int errors = 0;
  int checks = 0;

  div_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .div_control(div_control), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: signed division from magnitudes, quotient sign a^b, remainder sign a.
  task automatic ref_div(input logic [W-1:0] ra, input logic [W-1:0] rb,
                         output logic [W-1:0] rlo, output logic [W-1:0] rhi);
    logic [W-1:0] ua, ub, uq, ur;
    ua = ra[W-1] ? -ra : ra;
    ub = rb[W-1] ? -rb : rb;
    uq = ua / ub;
    ur = ua % ub;
    rlo = (ra[W-1] ^ rb[W-1]) ? -uq : uq;
    rhi = ra[W-1] ? -ur : ur;
  endtask

  // Called #1 after an edge; returns #1 after the edge where done is seen.
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input bit interfere);
    int cnt;
    int bad_busy;
    int saw_dz;
    a = ta; b = tb_; div_control = 1'b1;
    @(posedge clk); #1;
    div_control = 1'b0;
    chk({name, " busy_after_start"}, W'(busy), W'(1));
    cnt = 0; bad_busy = 0; saw_dz = 0;
    while (!done && cnt < 100) begin
      if (interfere && cnt == 5) begin
        a = 32'd100; b = 32'd0; div_control = 1'b1;
      end
      if (interfere && cnt == 8) div_control = 1'b0;
      @(posedge clk); #1;
      cnt++;
      if (!done && !busy) bad_busy++;
      if (div_zero) saw_dz++;
    end
    div_control = 1'b0;
    chk({name, " latency"}, W'(cnt), W'(33));
    chk({name, " lo"}, lo, elo);
    chk({name, " hi"}, hi, ehi);
    chk({name, " busy_gap"}, W'(bad_busy), W'(0));
    if (interfere) chk({name, " div_zero_during_run"}, W'(saw_dz), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, mlo, mhi;
    int limit;

    vecs[0] = '{32'd7,        32'd2,        32'd3,        32'd1};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[5] = '{32'd100,      32'd7,        32'd14,       32'd2};
    vecs[6] = '{32'd5,        32'd7,        32'd0,        32'd5};
    vecs[7] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
    vecs[8] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0};
    vecs[9] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};

    reset = 1'b1; div_control = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", W'(busy), 0);
    chk("reset done", W'(done), 0);
    chk("reset div_zero", W'(div_zero), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table; each op starts in the previous op's DONE cycle.
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b0);

    // Zero divisor after a 7/2 result.
    do_op("pre_zero", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    a = 32'd55; b = 32'd0; div_control = 1'b1;
    @(posedge clk); #1;
    div_control = 1'b0;
    chk("zero div_zero", W'(div_zero), 1);
    chk("zero busy", W'(busy), 0);
    chk("zero done", W'(done), 0);
    chk("zero lo", lo, 32'd3);
    chk("zero hi", hi, 32'd1);
    @(posedge clk); #1;
    chk("zero pulse_end", W'(div_zero), 0);
    chk("zero stays_idle", W'(busy), 0);

    // Start requests while busy must be ignored.
    do_op("ignored_start", 32'd7, 32'd2, 32'd3, 32'd1, 1'b1);
    @(posedge clk); #1;
    chk("after_done busy", W'(busy), 0);
    chk("after_done done", W'(done), 0);

    // Random operands against the model.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case (i % 3)
        0: rb = $urandom;
        1: rb = W'($urandom_range(1, 300));
        default: rb = -W'($urandom_range(1, 300));
      endcase
      if (rb == 0) rb = 32'd3;
      ref_div(ra, rb, mlo, mhi);
      do_op($sformatf("rnd%0d", i), ra, rb, mlo, mhi, 1'b0);
    end

    // Reset in the middle of a run abandons the operation.
    a = 32'd7; b = 32'd2; div_control = 1'b1;
    @(posedge clk); #1;
    div_control = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst busy", W'(busy), 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    chk("midrst done", W'(done), 0);
    limit = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) limit++;
    end
    chk("midrst no_done", W'(limit), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
